// File: rtl/lvds_7to1_rx_align_pkg.sv
// Shared definitions for the 7:1 LVDS receive word aligner: the aligner
// state encoding and the two legal clock-lane words.
package lvds_7to1_rx_align_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_VERIFY = 3'd1,
        ST_SLIP   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAULT  = 3'd4
    } rx_state_e;

    // 4:3 duty clock-lane word, the common choice
    localparam logic [6:0] CLK_PATTERN_STD = 7'b1100011;
    // Alternative clock-lane word some transmitters use
    localparam logic [6:0] CLK_PATTERN_ALT = 7'b1100001;

endpackage

// File: rtl/lvds_rx_pattern_det.sv
// Clock-lane pattern detector for the 7:1 LVDS aligner. Compares the
// deserialized clock word with the expected pattern and keeps the
// saturating consecutive-match and consecutive-miss counters. The FSM
// tells it which counter is live; the idle counter is held at zero so
// it starts clean on every entry to its state.
module lvds_rx_pattern_det
    import lvds_7to1_rx_align_pkg::*;
#(
    parameter logic [6:0] CLK_PATTERN = CLK_PATTERN_STD,
    parameter int         LOCK_COUNT  = 16,
    parameter int         LOSS_COUNT  = 4
) (
    input  logic       sclk,
    input  logic       reset,
    input  logic [6:0] clk_word,
    input  logic       verify_en,
    input  logic       locked_en,
    output logic       match,
    output logic       lock_hit,
    output logic       loss_hit
);

    logic [7:0] match_cnt_q, match_cnt_d;
    logic [3:0] miss_cnt_q, miss_cnt_d;

    assign match = (clk_word == CLK_PATTERN);

    // Next-count logic: count runs while enabled, saturate at the threshold, clear otherwise
    always_comb begin
        match_cnt_d = '0;
        miss_cnt_d  = '0;
        if (verify_en && match) begin
            match_cnt_d = (match_cnt_q == 8'(LOCK_COUNT)) ? match_cnt_q : match_cnt_q + 8'd1;
        end
        if (locked_en && !match) begin
            miss_cnt_d = (miss_cnt_q == 4'(LOSS_COUNT)) ? miss_cnt_q : miss_cnt_q + 4'd1;
        end
    end

    // Counter registers with synchronous reset
    always_ff @(posedge sclk) begin
        if (reset) begin
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // The hit flags fire on the word that completes the run, so the FSM moves on that edge
    assign lock_hit = verify_en && match  && (match_cnt_q == 8'(LOCK_COUNT - 1));
    assign loss_hit = locked_en && !match && (miss_cnt_q  == 4'(LOSS_COUNT - 1));

endmodule

// File: rtl/lvds_7to1_rx_align.sv
// Word aligner for the 7:1 LVDS receive path. Pulses calib (bitslip) on
// the deserializers until the clock-lane word equals CLK_PATTERN, then
// publishes the data-lane words with a valid flag and watches the lock.
// Optional feature macro: RX_AUTO_RELOCK_EN. When defined, a lost lock
// restarts the search with a slip; otherwise the aligner parks in FAULT
// until reset.
module lvds_7to1_rx_align
    import lvds_7to1_rx_align_pkg::*;
#(
    parameter int         LANES       = 4,
    parameter logic [6:0] CLK_PATTERN = CLK_PATTERN_STD,
    parameter int         SLIP_WAIT   = 4,
    parameter int         LOCK_COUNT  = 16,
    parameter int         LOSS_COUNT  = 4,
    parameter int         MAX_SLIPS   = 14
) (
    input  logic                 sclk,
    input  logic                 reset,
    input  logic [6:0]           clk_word,
    input  logic [7*LANES-1:0]   din,
    output logic                 calib,
    output logic                 locked,
    output logic [7*LANES-1:0]   dout,
    output logic                 dout_valid,
    output logic                 align_err
);

    rx_state_e          state_q, state_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [3:0]         slip_cnt_q, slip_cnt_d;
    logic               calib_q, calib_d;
    logic               locked_q, locked_d;
    logic [7*LANES-1:0] dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               align_err_q, align_err_d;
    logic               enter_slip;

    logic match;
    logic lock_hit;
    logic loss_hit;

    lvds_rx_pattern_det #(
        .CLK_PATTERN (CLK_PATTERN),
        .LOCK_COUNT  (LOCK_COUNT),
        .LOSS_COUNT  (LOSS_COUNT)
    ) u_pattern_det (
        .sclk      (sclk),
        .reset     (reset),
        .clk_word  (clk_word),
        .verify_en (state_q == ST_VERIFY),
        .locked_en (state_q == ST_LOCKED),
        .match     (match),
        .lock_hit  (lock_hit),
        .loss_hit  (loss_hit)
    );

    // Next-state and next-output logic; outputs are derived from the next state so they register with it
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        align_err_d = align_err_q;
        enter_slip  = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (wait_cnt_q == 4'(SLIP_WAIT - 1)) begin
                    state_d    = ST_VERIFY;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_VERIFY: begin
                if (lock_hit) begin
                    state_d    = ST_LOCKED;
                    slip_cnt_d = '0;
                end else if (!match) begin
                    enter_slip = 1'b1;
                end
            end
            ST_SLIP: begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end
            ST_LOCKED: begin
                if (loss_hit) begin
                    align_err_d = 1'b1;
`ifdef RX_AUTO_RELOCK_EN
                    enter_slip  = 1'b1;
`else
                    state_d     = ST_FAULT;
`endif
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        // Every slip is counted as it is issued; too many without a lock flags an error and the search goes on
        if (enter_slip) begin
            state_d = ST_SLIP;
            if (slip_cnt_q == 4'(MAX_SLIPS - 1)) begin
                slip_cnt_d  = '0;
                align_err_d = 1'b1;
            end else begin
                slip_cnt_d = slip_cnt_q + 4'd1;
            end
        end

        calib_d      = (state_d == ST_SLIP);
        locked_d     = (state_d == ST_LOCKED);
        // Valid only for words captured in LOCKED and not on the edge that drops lock, so it falls with locked
        dout_valid_d = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
        dout_d       = dout_valid_d ? din : '0;
    end

    // Aligner state and registered outputs, synchronous reset has priority
    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q      <= ST_WAIT;
            wait_cnt_q   <= '0;
            slip_cnt_q   <= '0;
            calib_q      <= 1'b0;
            locked_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            calib_q      <= calib_d;
            locked_q     <= locked_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            align_err_q  <= align_err_d;
        end
    end

    assign calib      = calib_q;
    assign locked     = locked_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign align_err  = align_err_q;

endmodule

// File: tb/tb_lvds_7to1_rx_align.sv
// Testbench for lvds_7to1_rx_align. A behavioural model of the alignment
// rules predicts every output each cycle; directed timing checks cover
// lock latency, bitslip search, lock loss, slip error and reset.
module tb_lvds_7to1_rx_align;

    localparam int         LANES = 4;
    localparam logic [6:0] PAT   = 7'b1100011;
    localparam int         SW    = 4;
    localparam int         LC    = 16;
    localparam int         LS    = 4;
    localparam int         MS    = 14;

    localparam int M_WAIT   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_SLIP   = 2;
    localparam int M_LOCKED = 3;
    localparam int M_FAULT  = 4;

    logic                 sclk = 1'b0;
    logic                 reset = 1'b1;
    logic [6:0]           clk_word = '0;
    logic [7*LANES-1:0]   din = '0;
    logic                 calib;
    logic                 locked;
    logic [7*LANES-1:0]   dout;
    logic                 dout_valid;
    logic                 align_err;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model
    int   m_mode = M_WAIT;
    int   m_wcnt = 0, m_run = 0, m_miss = 0, m_slips = 0;
    bit   m_err = 0;
    bit   auto_relock = 0;
    logic exp_calib = 0, exp_locked = 0, exp_valid = 0, exp_err = 0;
    logic [7*LANES-1:0] exp_dout = '0;

    // timing trackers, cycles counted from reset release
    int cyc = 0;
    int lock_cycle = -1;
    int calib_cnt = 0;
    int last_calib = -1;
    int min_gap = 1000, max_gap = 0;
    int err_slip = -1;

    lvds_7to1_rx_align #(
        .LANES       (LANES),
        .CLK_PATTERN (PAT),
        .SLIP_WAIT   (SW),
        .LOCK_COUNT  (LC),
        .LOSS_COUNT  (LS),
        .MAX_SLIPS   (MS)
    ) dut (
        .sclk       (sclk),
        .reset      (reset),
        .clk_word   (clk_word),
        .din        (din),
        .calib      (calib),
        .locked     (locked),
        .dout       (dout),
        .dout_valid (dout_valid),
        .align_err  (align_err)
    );

    always #5 sclk = ~sclk;

    function automatic logic [6:0] rotWord(input int off);
        logic [13:0] dbl;
        dbl = {PAT, PAT};
        return dbl[off +: 7];
    endfunction

    function automatic logic [6:0] badWord();
        logic [6:0] w;
        do w = 7'($urandom); while (w == PAT);
        return w;
    endfunction

    task automatic modelStep(input logic rst, input logic [6:0] cw, input logic [7*LANES-1:0] d);
        int prev;
        bit hit;
        bit to_slip;
        if (rst) begin
            m_mode = M_WAIT; m_wcnt = 0; m_run = 0; m_miss = 0; m_slips = 0; m_err = 0;
            exp_calib = 0; exp_locked = 0; exp_valid = 0; exp_err = 0; exp_dout = '0;
            return;
        end
        prev = m_mode;
        hit = (cw == PAT);
        to_slip = 0;
        case (prev)
            M_WAIT: begin
                m_wcnt++;
                if (m_wcnt == SW) begin m_wcnt = 0; m_mode = M_VERIFY; end
            end
            M_VERIFY: begin
                if (hit) begin
                    m_run++;
                    if (m_run == LC) begin m_run = 0; m_slips = 0; m_miss = 0; m_mode = M_LOCKED; end
                end else begin
                    m_run = 0;
                    to_slip = 1;
                end
            end
            M_SLIP: m_mode = M_WAIT;
            M_LOCKED: begin
                if (hit) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss == LS) begin
                        m_miss = 0;
                        m_err = 1;
                        if (auto_relock) to_slip = 1;
                        else m_mode = M_FAULT;
                    end
                end
            end
            default: ;
        endcase
        if (to_slip) begin
            m_mode = M_SLIP;
            m_slips++;
            if (m_slips == MS) begin m_slips = 0; m_err = 1; end
        end
        exp_calib  = (m_mode == M_SLIP);
        exp_locked = (m_mode == M_LOCKED);
        exp_valid  = (prev == M_LOCKED) && (m_mode == M_LOCKED);
        exp_dout   = exp_valid ? d : '0;
        exp_err    = m_err;
    endtask

    task automatic checkValue(input string tag, input int obs, input int expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        tests_run++;
        assert (calib === exp_calib) else begin
            tests_failed++;
            $error("[TB] FAIL calib cyc %0d: observed %0b expected %0b", cyc, calib, exp_calib);
        end
        tests_run++;
        assert (locked === exp_locked) else begin
            tests_failed++;
            $error("[TB] FAIL locked cyc %0d: observed %0b expected %0b", cyc, locked, exp_locked);
        end
        tests_run++;
        assert (dout_valid === exp_valid) else begin
            tests_failed++;
            $error("[TB] FAIL dout_valid cyc %0d: observed %0b expected %0b", cyc, dout_valid, exp_valid);
        end
        tests_run++;
        assert (dout === exp_dout) else begin
            tests_failed++;
            $error("[TB] FAIL dout cyc %0d: observed %h expected %h", cyc, dout, exp_dout);
        end
        tests_run++;
        assert (align_err === exp_err) else begin
            tests_failed++;
            $error("[TB] FAIL align_err cyc %0d: observed %0b expected %0b", cyc, align_err, exp_err);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [6:0] cw);
        logic [7*LANES-1:0] d;
        d = 28'($urandom);
        reset = rst;
        clk_word = cw;
        din = d;
        @(posedge sclk);
        #1;
        modelStep(rst, cw, d);
        if (rst) begin
            cyc = 0; lock_cycle = -1; calib_cnt = 0; last_calib = -1;
            min_gap = 1000; max_gap = 0; err_slip = -1;
        end else begin
            cyc++;
            if (calib === 1'b1) begin
                calib_cnt++;
                if (last_calib >= 0) begin
                    if (cyc - last_calib < min_gap) min_gap = cyc - last_calib;
                    if (cyc - last_calib > max_gap) max_gap = cyc - last_calib;
                end
                last_calib = cyc;
            end
            if (locked === 1'b1 && lock_cycle < 0) lock_cycle = cyc + 1;
            if (align_err === 1'b1 && err_slip < 0) err_slip = calib_cnt;
        end
        checkOutput();
    endtask

    task automatic checkAllZero(input string tag);
        checkValue(tag, int'({calib, locked, dout_valid, align_err, |dout}), 0);
    endtask

    initial begin
        int off;
        int cyc_loss;
`ifdef RX_AUTO_RELOCK_EN
        auto_relock = 1;
`else
        auto_relock = 0;
`endif
        // Test 1: aligned from reset release
        applyStimulus(1, PAT);
        applyStimulus(1, PAT);
        checkAllZero("t1_reset_zero");
        for (int i = 0; i < 30; i++) applyStimulus(0, PAT);
        checkValue("t1_lock_cycle", lock_cycle, SW + LC + 1);
        checkValue("t1_no_calib", calib_cnt, 0);

        // Test 3: short miss run keeps lock, full miss run drops it
        for (int i = 0; i < 3; i++) applyStimulus(0, badWord());
        applyStimulus(0, PAT);
        checkValue("t3_hold_locked", int'(locked), 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, badWord());
        cyc_loss = cyc;
        checkValue("t3_lost_locked", int'(locked), 0);
        checkValue("t3_lost_valid", int'(dout_valid), 0);
        checkValue("t3_err_set", int'(align_err), 1);

        // Test 6: correct pattern after loss
        lock_cycle = -1;
        for (int i = 0; i < 40; i++) applyStimulus(0, PAT);
        if (auto_relock) begin
            checkValue("t6_relock_delay", (lock_cycle - 1) - cyc_loss, LC + SW + 1);
        end else begin
            checkValue("t6_stays_unlocked", lock_cycle, -1);
        end

        // Test 5: reset mid-VERIFY and in LOCKED
        applyStimulus(1, PAT);
        checkAllZero("t5_reset_after_fault");
        for (int i = 0; i < 10; i++) applyStimulus(0, PAT);
        applyStimulus(1, PAT);
        checkAllZero("t5_reset_verify");
        for (int i = 0; i < 25; i++) applyStimulus(0, PAT);
        checkValue("t5_relock_cycle_a", lock_cycle, SW + LC + 1);
        applyStimulus(1, PAT);
        checkAllZero("t5_reset_locked");
        for (int i = 0; i < 25; i++) applyStimulus(0, PAT);
        checkValue("t5_relock_cycle_b", lock_cycle, SW + LC + 1);

        // Test 2: bitslip search from 3 slips away, then a random offset
        for (int pass = 0; pass < 2; pass++) begin
            off = (pass == 0) ? 3 : int'($urandom_range(1, 6));
            applyStimulus(1, PAT);
            for (int i = 0; i < 70; i++) begin
                applyStimulus(0, rotWord(off));
                if (exp_calib) off = (off == 0) ? 6 : off - 1;
            end
            checkValue("t2_slip_count", calib_cnt, (pass == 0) ? 3 : calib_cnt);
            checkValue("t2_lock_cycle", lock_cycle, calib_cnt * (SW + 2) + SW + LC + 1);
            checkValue("t2_no_err", int'(align_err), 0);
        end

        // Test 4: no pattern at all
        applyStimulus(1, 7'd0);
        for (int i = 0; i < 100; i++) applyStimulus(0, 7'd0);
        checkValue("t4_err_at_slip", err_slip, MS);
        checkValue("t4_min_gap", min_gap, SW + 2);
        checkValue("t4_max_gap", max_gap, SW + 2);
        checkValue("t4_slips_continue", calib_cnt, 16);
        checkValue("t4_err_sticky", int'(align_err), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
